ddr_amm_arbiter: RTL and testbench

Two-requester Avalon-MM arbiter sharing the single DDR EMIF Avalon port (25-bit word address, 256-bit data, 7-bit burstcount) on the `avalon_clk` domain. It sits between the DDR setup logic's downstream port and the EMIF. It holds all traffic until `setup_done` is high. Write bursts are granted atomically. Read commands are pipelined, with responses steered back to their issuer through an outstanding-read tag FIFO.

---
 rtl/ddr_amm_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ddr_amm_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_amm_arbiter.sv
// Two-requester Avalon-MM arbiter for the DDR EMIF port with read-tag return steering.
// Define DDR_ARB_FIXED_PRIO_EN to make requester 0 always win contention instead of round-robin.
module ddr_amm_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned ADDR_W          = 25,
   parameter int unsigned DATA_W          = 256,
   parameter int unsigned BE_W            = 32,
   parameter int unsigned BC_W            = 7
) (
   input  logic              avalon_clk,
   input  logic              avalon_reset,
   input  logic              setup_done,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_writedata,
   input  logic [BE_W-1:0]   r0_byteenable,
   input  logic [BC_W-1:0]   r0_burstcount,
   input  logic              r0_read,
   input  logic              r0_write,
   output logic              r0_ready,
   output logic [DATA_W-1:0] r0_readdata,
   output logic              r0_readdatavalid,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_writedata,
   input  logic [BE_W-1:0]   r1_byteenable,
   input  logic [BC_W-1:0]   r1_burstcount,
   input  logic              r1_read,
   input  logic              r1_write,
   output logic              r1_ready,
   output logic [DATA_W-1:0] r1_readdata,
   output logic              r1_readdatavalid,
   output logic [ADDR_W-1:0] amm_addr,
   output logic [DATA_W-1:0] amm_writedata,
   output logic [BE_W-1:0]   amm_byteenable,
   output logic [BC_W-1:0]   amm_burstcount,
   output logic              amm_read,
   output logic              amm_write,
   input  logic [DATA_W-1:0] amm_readdata,
   input  logic              amm_readdatavalid,
   input  logic              amm_ready,
   output logic              err_unexpected_rdata
);

   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);

   typedef enum logic [1:0] {IDLE, GRANT_RD, GRANT_WR} state_t;

   state_t            state;
   logic              gnt_id;
   logic [ADDR_W-1:0] addr_q;
   logic [BC_W-1:0]   bc_q;
   logic [BC_W-1:0]   beat_cnt;

   logic [PTR_W:0]    wr_ptr;
   logic [PTR_W:0]    rd_ptr;
   logic              tag_id [MAX_OUTSTANDING];
   logic [BC_W-1:0]   tag_bc [MAX_OUTSTANDING];
   logic [BC_W-1:0]   ret_cnt;

   logic              fifo_full, fifo_empty, push, pop, head_id, beat_ok;
   logic [BC_W-1:0]   head_bc;
   logic              elig0, elig1, win_id, win_wr;
   logic [BC_W-1:0]   win_bc;
   logic              sel_rd, sel_wr, cmd_acc;

   function automatic logic [BC_W-1:0] eff_bc(input logic [BC_W-1:0] bc);
      return (bc == '0) ? BC_W'(1) : bc;
   endfunction

   // Arbitration: eligibility, winner selection and the winner's command type
   assign elig0  = setup_done & (r0_write | (r0_read & ~fifo_full));
   assign elig1  = setup_done & (r1_write | (r1_read & ~fifo_full));
`ifdef DDR_ARB_FIXED_PRIO_EN
   assign win_id = ~elig0;
`else
   logic last_id;
   assign win_id = (elig0 & elig1) ? ~last_id : elig1;

   always_ff @(posedge avalon_clk or posedge avalon_reset) begin
      if (avalon_reset)                          last_id <= 1'b1;
      else if (state == IDLE && (elig0 | elig1)) last_id <= win_id;
   end
`endif
   assign win_wr = win_id ? r1_write : r0_write;
   assign win_bc = eff_bc(win_id ? r1_burstcount : r0_burstcount);

   // Address and burstcount are captured at grant so they hold for the whole burst;
   // write data and byteenable follow the granted requester beat by beat.
   assign sel_rd = gnt_id ? r1_read  : r0_read;
   assign sel_wr = gnt_id ? r1_write : r0_write;

   assign amm_read       = (state == GRANT_RD) & sel_rd;
   assign amm_write      = (state == GRANT_WR) & sel_wr;
   assign amm_addr       = (state == IDLE) ? '0 : addr_q;
   assign amm_burstcount = (state == IDLE) ? '0 : bc_q;
   assign amm_writedata  = (state == GRANT_WR) ? (gnt_id ? r1_writedata : r0_writedata) : '0;
   assign amm_byteenable = (state == IDLE) ? '0 : (gnt_id ? r1_byteenable : r0_byteenable);

   assign cmd_acc  = amm_ready & (amm_read | amm_write);
   assign r0_ready = cmd_acc & ~gnt_id;
   assign r1_ready = cmd_acc & gnt_id;

   always_ff @(posedge avalon_clk or posedge avalon_reset) begin
      if (avalon_reset) begin
         state    <= IDLE;
         gnt_id   <= 1'b0;
         addr_q   <= '0;
         bc_q     <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (elig0 | elig1) begin
                  gnt_id   <= win_id;
                  addr_q   <= win_id ? r1_addr : r0_addr;
                  bc_q     <= win_bc;
                  beat_cnt <= win_bc;
                  state    <= win_wr ? GRANT_WR : GRANT_RD;
               end
            end
            GRANT_RD: begin
               if (amm_read & amm_ready) state <= IDLE;
            end
            GRANT_WR: begin
               if (amm_write & amm_ready) begin
                  beat_cnt <= beat_cnt - BC_W'(1);
                  if (beat_cnt == BC_W'(1)) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outstanding-read tag FIFO: {requester id, beats expected}
   assign push       = amm_read & amm_ready;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign head_id    = tag_id[rd_ptr[PTR_W-1:0]];
   assign head_bc    = tag_bc[rd_ptr[PTR_W-1:0]];
   assign beat_ok    = amm_readdatavalid & ~fifo_empty;
   assign pop        = beat_ok & ((ret_cnt + BC_W'(1)) == head_bc);

   always_ff @(posedge avalon_clk) begin
      if (push) begin
         tag_id[wr_ptr[PTR_W-1:0]] <= gnt_id;
         tag_bc[wr_ptr[PTR_W-1:0]] <= bc_q;
      end
   end

   always_ff @(posedge avalon_clk or posedge avalon_reset) begin
      if (avalon_reset) begin
         wr_ptr               <= '0;
         rd_ptr               <= '0;
         ret_cnt              <= '0;
         err_unexpected_rdata <= 1'b0;
         r0_readdatavalid     <= 1'b0;
         r1_readdatavalid     <= 1'b0;
         r0_readdata          <= '0;
         r1_readdata          <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
         if (amm_readdatavalid & fifo_empty) err_unexpected_rdata <= 1'b1;
         if (beat_ok) ret_cnt <= pop ? '0 : ret_cnt + BC_W'(1);
         r0_readdatavalid <= beat_ok & ~head_id;
         r1_readdatavalid <= beat_ok & head_id;
         if (beat_ok & ~head_id) r0_readdata <= amm_readdata;
         if (beat_ok & head_id)  r1_readdata <= amm_readdata;
      end
   end

endmodule

// File: tb/tb_ddr_amm_arbiter.sv
// Directed self-checking bench for ddr_amm_arbiter; the EMIF side is driven by hand from the stimulus.
module tb_ddr_amm_arbiter;

   logic          avalon_clk = 1'b0;
   logic          avalon_reset = 1'b0;
   logic          setup_done = 1'b0;
   logic [24:0]   r0_addr = '0, r1_addr = '0;
   logic [255:0]  r0_writedata = '0, r1_writedata = '0;
   logic [31:0]   r0_byteenable = '1, r1_byteenable = '1;
   logic [6:0]    r0_burstcount = '0, r1_burstcount = '0;
   logic          r0_read = 1'b0, r0_write = 1'b0, r1_read = 1'b0, r1_write = 1'b0;
   logic          r0_ready, r1_ready, r0_readdatavalid, r1_readdatavalid;
   logic [255:0]  r0_readdata, r1_readdata;
   logic [24:0]   amm_addr;
   logic [255:0]  amm_writedata;
   logic [31:0]   amm_byteenable;
   logic [6:0]    amm_burstcount;
   logic          amm_read, amm_write;
   logic [255:0]  amm_readdata = '0;
   logic          amm_readdatavalid = 1'b0;
   logic          amm_ready = 1'b1;
   logic          err_unexpected_rdata;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 avalon_clk = ~avalon_clk;

   ddr_amm_arbiter dut (
      .avalon_clk(avalon_clk), .avalon_reset(avalon_reset), .setup_done(setup_done),
      .r0_addr(r0_addr), .r0_writedata(r0_writedata), .r0_byteenable(r0_byteenable),
      .r0_burstcount(r0_burstcount), .r0_read(r0_read), .r0_write(r0_write),
      .r0_ready(r0_ready), .r0_readdata(r0_readdata), .r0_readdatavalid(r0_readdatavalid),
      .r1_addr(r1_addr), .r1_writedata(r1_writedata), .r1_byteenable(r1_byteenable),
      .r1_burstcount(r1_burstcount), .r1_read(r1_read), .r1_write(r1_write),
      .r1_ready(r1_ready), .r1_readdata(r1_readdata), .r1_readdatavalid(r1_readdatavalid),
      .amm_addr(amm_addr), .amm_writedata(amm_writedata), .amm_byteenable(amm_byteenable),
      .amm_burstcount(amm_burstcount), .amm_read(amm_read), .amm_write(amm_write),
      .amm_readdata(amm_readdata), .amm_readdatavalid(amm_readdatavalid),
      .amm_ready(amm_ready), .err_unexpected_rdata(err_unexpected_rdata)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic cyc();
      @(posedge avalon_clk);
      #2;
   endtask

   initial begin
      int exp_id;

      // Reset state
      #1 avalon_reset = 1'b1;
      #2;
      chk("rst_amm_write", amm_write, 0);
      chk("rst_amm_read", amm_read, 0);
      chk("rst_amm_addr", amm_addr, 0);
      chk("rst_amm_bc", amm_burstcount, 0);
      chk("rst_r0_ready", r0_ready, 0);
      chk("rst_r1_rdv", r1_readdatavalid, 0);
      chk("rst_err", err_unexpected_rdata, 0);
      cyc(); cyc();
      avalon_reset = 1'b0;

      // Gating: a held write is not granted until setup_done rises
      r0_write = 1'b1; r0_addr = 25'h040; r0_burstcount = 7'd1; r0_writedata = 256'h1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("gate_no_write", amm_write, 0);
      end
      setup_done = 1'b1;
      #1;
      chk("gate_same_cycle", amm_write, 0);
      cyc();
      chk("gate_grant_write", amm_write, 1);
      chk("gate_grant_addr", amm_addr, 25'h040);
      chk("gate_grant_ready", r0_ready, 1);
      chk("gate_grant_wdata", amm_writedata, 256'h1);
      cyc();
      r0_write = 1'b0;
      #1;
      chk("gate_back_idle", amm_write, 0);

      // Atomic 4-beat write from r0 while r1 waits with a read
      r0_write = 1'b1; r0_addr = 25'h100; r0_burstcount = 7'd4;
      cyc();
      r1_read = 1'b1; r1_addr = 25'h200; r1_burstcount = 7'd1;
      for (int k = 0; k < 4; k++) begin
         r0_writedata = 256'(32'hA0 + k);
         if (k == 2) begin
            amm_ready = 1'b0;
            #1;
            chk("wr_stall_ready", r0_ready, 0);
            cyc();
            amm_ready = 1'b1;
         end
         #1;
         chk("wr_beat_write", amm_write, 1);
         chk("wr_beat_data", amm_writedata, 256'(32'hA0 + k));
         chk("wr_beat_bc", amm_burstcount, 4);
         chk("wr_beat_addr", amm_addr, 25'h100);
         chk("wr_beat_r0_ready", r0_ready, 1);
         chk("wr_beat_r1_ready", r1_ready, 0);
         chk("wr_beat_no_read", amm_read, 0);
         cyc();
      end
      r0_write = 1'b0;
      #1;
      chk("wr_done_idle", amm_write, 0);
      cyc();
      chk("wr_then_r1_read", amm_read, 1);
      chk("wr_then_r1_addr", amm_addr, 25'h200);
      chk("wr_then_r1_ready", r1_ready, 1);
      chk("wr_then_r0_ready", r0_ready, 0);
      cyc();
      r1_read = 1'b0;
      amm_readdatavalid = 1'b1; amm_readdata = 256'hD1;
      cyc();
      amm_readdatavalid = 1'b0;
      chk("r1_ret_valid", r1_readdatavalid, 1);
      chk("r1_ret_data", r1_readdata, 256'hD1);
      chk("r1_ret_r0_valid", r0_readdatavalid, 0);
      cyc();
      chk("r1_ret_valid_drop", r1_readdatavalid, 0);

      // Continuous single writes from both requesters
      r0_write = 1'b1; r0_addr = 25'h300; r0_burstcount = 7'd1;
      r1_write = 1'b1; r1_addr = 25'h301; r1_burstcount = 7'd1;
      for (int i = 0; i < 4; i++) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
         exp_id = 0;
`else
         exp_id = i % 2;
`endif
         cyc();
         chk("rr_write", amm_write, 1);
         chk("rr_addr", amm_addr, 25'(32'h300 + exp_id));
         chk("rr_r0_ready", r0_ready, (exp_id == 0));
         chk("rr_r1_ready", r1_ready, (exp_id == 1));
         cyc();
         chk("rr_idle_gap", amm_write, 0);
      end
      r0_write = 1'b0; r1_write = 1'b0;

      // Read steering: r0 burst of 2, then r1 burstcount 0 (one beat)
      r0_read = 1'b1; r0_addr = 25'h400; r0_burstcount = 7'd2;
      cyc();
      chk("rs_r0_read", amm_read, 1);
      chk("rs_r0_bc", amm_burstcount, 2);
      chk("rs_r0_ready", r0_ready, 1);
      cyc();
      r0_read = 1'b0;
      r1_read = 1'b1; r1_addr = 25'h500; r1_burstcount = 7'd0;
      #1;
      chk("rs_idle_gap", amm_read, 0);
      cyc();
      chk("rs_r1_bc_eff", amm_burstcount, 1);
      chk("rs_r1_addr", amm_addr, 25'h500);
      chk("rs_r1_ready", r1_ready, 1);
      cyc();
      r1_read = 1'b0;
      amm_readdatavalid = 1'b1; amm_readdata = 256'hB1;
      cyc();
      chk("rs_b1_r0_valid", r0_readdatavalid, 1);
      chk("rs_b1_r0_data", r0_readdata, 256'hB1);
      chk("rs_b1_r1_valid", r1_readdatavalid, 0);
      amm_readdata = 256'hB2;
      cyc();
      chk("rs_b2_r0_valid", r0_readdatavalid, 1);
      chk("rs_b2_r0_data", r0_readdata, 256'hB2);
      amm_readdata = 256'hB3;
      cyc();
      chk("rs_b3_r1_valid", r1_readdatavalid, 1);
      chk("rs_b3_r1_data", r1_readdata, 256'hB3);
      chk("rs_b3_r0_valid", r0_readdatavalid, 0);
      amm_readdatavalid = 1'b0;
      cyc();
      chk("rs_done_r1_valid", r1_readdatavalid, 0);
      chk("rs_no_err", err_unexpected_rdata, 0);

      // FIFO full: four reads accepted, fifth held back while a write still goes through
      r0_read = 1'b1; r0_addr = 25'h410; r0_burstcount = 7'd1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("full_rd_grant", amm_read, 1);
         cyc();
      end
      cyc();
      chk("full_blocked_read", amm_read, 0);
      chk("full_blocked_ready", r0_ready, 0);
      r1_write = 1'b1; r1_addr = 25'h600; r1_burstcount = 7'd1;
      cyc();
      chk("full_wr_grant", amm_write, 1);
      chk("full_wr_ready", r1_ready, 1);
      chk("full_wr_addr", amm_addr, 25'h600);
      cyc();
      r1_write = 1'b0;
      cyc();
      chk("full_still_blocked", amm_read, 0);
      amm_readdatavalid = 1'b1; amm_readdata = 256'hC1;
      cyc();
      amm_readdatavalid = 1'b0;
      chk("full_pop_valid", r0_readdatavalid, 1);
      chk("full_pop_data", r0_readdata, 256'hC1);
      chk("full_pop_no_grant_yet", amm_read, 0);
      cyc();
      chk("full_fifth_read", amm_read, 1);
      chk("full_fifth_ready", r0_ready, 1);
      cyc();
      r0_read = 1'b0;

      // Drain the four outstanding single-beat reads
      amm_readdatavalid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         amm_readdata = 256'(32'hC2 + k);
         cyc();
         chk("drain_valid", r0_readdatavalid, 1);
         chk("drain_data", r0_readdata, 256'(32'hC2 + k));
      end
      amm_readdatavalid = 1'b0;
      cyc();
      chk("drain_done_valid", r0_readdatavalid, 0);
      chk("drain_no_err", err_unexpected_rdata, 0);

      // Read beat with nothing outstanding
      amm_readdatavalid = 1'b1; amm_readdata = 256'hEE;
      cyc();
      amm_readdatavalid = 1'b0;
      chk("unexp_err", err_unexpected_rdata, 1);
      chk("unexp_r0_drop", r0_readdatavalid, 0);
      chk("unexp_r1_drop", r1_readdatavalid, 0);
      cyc();
      chk("unexp_err_sticky", err_unexpected_rdata, 1);

      // Reset in the middle of a write burst
      r0_write = 1'b1; r0_addr = 25'h700; r0_burstcount = 7'd4;
      cyc();
      cyc();
      chk("mid_burst_write", amm_write, 1);
      avalon_reset = 1'b1;
      #1;
      chk("rst_mid_write", amm_write, 0);
      chk("rst_mid_addr", amm_addr, 0);
      chk("rst_mid_bc", amm_burstcount, 0);
      chk("rst_mid_ready", r0_ready, 0);
      chk("rst_mid_err", err_unexpected_rdata, 0);
      chk("rst_mid_rdata", r0_readdata, 0);
      r0_write = 1'b0;
      cyc();
      avalon_reset = 1'b0;
      r0_write = 1'b1; r0_burstcount = 7'd1;
      #1;
      chk("post_rst_idle", amm_write, 0);
      cyc();
      chk("post_rst_grant", amm_write, 1);
      chk("post_rst_bc", amm_burstcount, 1);
      cyc();
      r0_write = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
